// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter.
// Optional byte statistics: define UART_TX_ARB_STATS_EN.
package uart_arb_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_e;

  typedef struct packed {
    logic [BYTE_W*WORD_BYTES-1:0] data;
    logic [1:0]                   len;
  } tx_req_t;

  function automatic logic [BYTE_W-1:0] byte_of(
    input logic [BYTE_W*WORD_BYTES-1:0] data,
    input logic [1:0]                   idx
  );
    return data[{idx, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Two-way round-robin pick: ties go to the
// requester that was not served last.
module uart_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant,
  output logic any
);

  assign any   = valid0 | valid1;
  assign grant = (valid0 & valid1) ? ~last : valid1;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester word arbiter feeding a byte UART.
// Define UART_TX_ARB_STATS_EN for byte counters.
import uart_arb_pkg::*;

module uart_tx_arbiter #(
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_WAIT  = 8
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic [1:0]  req0_len,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic [1:0]  req1_len,
  output logic        req1_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        owner,
`ifdef UART_TX_ARB_STATS_EN
  output logic [31:0] bytes0,
  output logic [31:0] bytes1,
`endif
  output logic        active
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(BUSY_WAIT + 1);

  state_e        state;
  tx_req_t       req;
  logic [1:0]    idx;
  logic [GW-1:0] gcnt;
  logic [WW-1:0] wcnt;
  logic          last;
  logic          grant;
  logic          any;
  logic          byte_done;
  logic          last_byte;
  logic          wait_out;

  uart_rr_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last),
    .grant  (grant),
    .any    (any)
  );

  assign wait_out  = (wcnt == WW'(BUSY_WAIT - 1));
  assign last_byte = (idx == req.len);

  // A missing busy acknowledge still retires the byte.
  assign byte_done = !tx_busy &&
    ((state == S_WAIT_ACK && wait_out) ||
     state == S_WAIT_DONE);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      req        <= '0;
      idx        <= '0;
      gcnt       <= '0;
      wcnt       <= '0;
      last       <= 1'b1;
      owner      <= 1'b0;
      active     <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      tx_start   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any && !tx_busy) begin
            req <= grant ?
              {req1_data, req1_len} :
              {req0_data, req0_len};
            owner      <= grant;
            active     <= 1'b1;
            idx        <= '0;
            req0_ready <= ~grant;
            req1_ready <= grant;
            state      <= S_START;
          end
        end
        S_START: begin
          tx_start <= 1'b1;
          tx_data  <= byte_of(req.data, idx);
          wcnt     <= '0;
          state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy) state <= S_WAIT_DONE;
          else         wcnt  <= wcnt + 1'b1;
        end
        S_WAIT_DONE: ;
        S_GAP: begin
          if (gcnt == GW'(GAP_CYCLES - 1))
            state <= S_START;
          else
            gcnt <= gcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      if (byte_done) begin
        if (last_byte) begin
          state  <= S_IDLE;
          active <= 1'b0;
          last   <= owner;
        end else begin
          state <= S_GAP;
          gcnt  <= '0;
          idx   <= idx + 1'b1;
        end
      end
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bytes0 <= '0;
      bytes1 <= '0;
    end else if (byte_done) begin
      if (owner) bytes1 <= bytes1 + 1'b1;
      else       bytes0 <= bytes0 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timeline model plus
// directed words; UART_TX_ARB_STATS_EN adds stats.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int G  = 16;
  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data = '0;
  logic [1:0]  req0_len = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data = '0;
  logic [1:0]  req1_len = '0;
  logic        req1_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        owner;
  logic        active;
`ifdef UART_TX_ARB_STATS_EN
  logic [31:0] bytes0;
  logic [31:0] bytes1;
`endif

  uart_tx_arbiter #(
    .GAP_CYCLES (G),
    .BUSY_WAIT  (BW)
  ) dut (
    .clk        (clk),
    .Rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_len   (req0_len),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_len   (req1_len),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .owner      (owner),
`ifdef UART_TX_ARB_STATS_EN
    .bytes0     (bytes0),
    .bytes1     (bytes1),
`endif
    .active     (active)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int busy_len = 0;
  int e = 0;

  // model state: one word as a timeline of edges
  bit          m_word = 0;
  bit          m_own = 0;
  bit          m_last = 1;
  int          m_e0, m_fl, m_n;
  int          m_ts[4];
  int          m_fk[4];
  logic [31:0] m_d;
  bit          x_r0, x_r1, x_st, x_act, x_own;
  logic [7:0]  x_data = '0;
  int unsigned x_b0 = 0;
  int unsigned x_b1 = 0;

  logic [7:0] q_bytes[$];
  int         q_t[$];
  bit         q_own[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  // UART model: busy for busy_len cycles after tx_start
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_start && busy_len > 0) begin
      tx_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // model: schedule words from the stated timing rules
  initial forever begin
    bit w;
    int s, f;
    @(posedge clk);
    e++;
    x_r0 = 0;
    x_r1 = 0;
    x_st = 0;
    if (!rst_n) begin
      m_word = 0;
      m_last = 1;
      x_act = 0;
      x_own = 0;
      x_data = '0;
      x_b0 = 0;
      x_b1 = 0;
    end else begin
      if ((!m_word || e > m_fl) &&
          (req0_valid || req1_valid) && !tx_busy) begin
        w = (req0_valid && req1_valid) ?
            !m_last : req1_valid;
        m_last = w;
        m_own = w;
        m_word = 1;
        m_e0 = e;
        m_d = w ? req1_data : req0_data;
        m_n = (w ? int'(req1_len) : int'(req0_len)) + 1;
        s = e;
        f = e;
        for (int k = 0; k < m_n; k++) begin
          m_ts[k] = s + 1;
          f = (busy_len > 0) ? s + 2 + busy_len
                             : s + 1 + BW;
          m_fk[k] = f;
          s = f + G;
        end
        m_fl = f;
      end
      if (m_word) begin
        x_r0 = (e == m_e0) && !m_own;
        x_r1 = (e == m_e0) && m_own;
        if (e == m_e0) x_own = m_own;
        x_act = (e >= m_e0) && (e < m_fl);
        for (int k = 0; k < m_n; k++) begin
          if (e == m_ts[k]) begin
            x_st = 1;
            x_data = m_d[8*k +: 8];
          end
          if (e == m_fk[k]) begin
            if (m_own) x_b1++;
            else       x_b0++;
          end
        end
      end
    end
  end

  // per-cycle compare and event recorder
  initial forever begin
    logic [12:0] act_v, exp_v;
    @(negedge clk);
    exp_v = rst_n ?
      {x_r0, x_r1, x_st, x_data, x_own, x_act} : '0;
    act_v = {req0_ready, req1_ready, tx_start,
             tx_data, owner, active};
    n_chk++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL cycle e=%0d act=%h exp=%h",
                  e, act_v, exp_v);
`ifdef UART_TX_ARB_STATS_EN
    chk("stat_b0", bytes0, rst_n ? x_b0 : 0);
    chk("stat_b1", bytes1, rst_n ? x_b1 : 0);
`endif
    if (tx_start) begin
      q_bytes.push_back(tx_data);
      q_t.push_back(e);
    end
    if (req0_ready || req1_ready) q_own.push_back(owner);
  end

  task automatic clear_q();
    q_bytes.delete();
    q_t.delete();
    q_own.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input bit i,
                      input logic [31:0] d,
                      input logic [1:0] l);
    int n = 0;
    bit rdy;
    @(posedge clk);
    #1;
    if (i) begin
      req1_data = d; req1_len = l; req1_valid = 1'b1;
    end else begin
      req0_data = d; req0_len = l; req0_valid = 1'b1;
    end
    do begin
      @(posedge clk);
      #1;
      n++;
      rdy = i ? req1_ready : req0_ready;
    end while (!rdy && n < 3000);
    if (i) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
    if (!rdy) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((active || x_act) && n < 3000);
    if (active) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_active", active, 0);
    chk("rst_owner", owner, 0);

    // single req0 word, slow UART
    busy_len = 100;
    clear_q();
    send(0, 32'h0000_0030, 2'd3);
    wait_idle();
    chk("w0_nbytes", q_bytes.size(), 4);
    chk("w0_b0", q_bytes[0], 8'h30);
    chk("w0_b1", q_bytes[1], 8'h00);
    chk("w0_b3", q_bytes[3], 8'h00);
    chk("w0_ready", q_own.size(), 1);
    chk("w0_spacing", q_t[1] - q_t[0], 118);

    // simultaneous request right after reset
    do_reset();
    busy_len = 0;
    clear_q();
    fork
      send(0, 32'h0000_00AB, 2'd0);
      send(1, 32'h0000_00CD, 2'd0);
    join
    wait_idle();
    chk("tie_n", q_own.size(), 2);
    chk("tie_own0", q_own[0], 0);
    chk("tie_own1", q_own[1], 1);
    chk("tie_b0", q_bytes[0], 8'hAB);
    chk("tie_b1", q_bytes[1], 8'hCD);

    // req1 held, req0 pulsing: strict alternation
    clear_q();
    fork
      repeat (3) send(0, 32'h0000_00C3, 2'd0);
      begin
        int c = 0;
        int n = 0;
        @(posedge clk);
        #1;
        req1_data = 32'h0000_005A;
        req1_len = 2'd0;
        req1_valid = 1'b1;
        while (c < 3 && n < 3000) begin
          @(posedge clk);
          #1;
          n++;
          if (req1_ready) c++;
        end
        req1_valid = 1'b0;
        chk("alt_r1_cnt", c, 3);
      end
    join
    wait_idle();
    chk("alt_n", q_own.size(), 6);
    for (int i = 0; i < q_own.size(); i++)
      chk($sformatf("alt_own%0d", i), q_own[i], i % 2);

    // no busy acknowledge at all
    clear_q();
    send(1, 32'hDDCC_BBAA, 2'd3);
    wait_idle();
    chk("nb_nbytes", q_bytes.size(), 4);
    chk("nb_b3", q_bytes[3], 8'hDD);
    chk("nb_own", q_own[0], 1);
    chk("nb_spacing", q_t[1] - q_t[0], 25);
    chk("nb_idle", active, 0);

    // reset in the middle of byte 2
    busy_len = 20;
    clear_q();
    send(1, 32'h4433_2211, 2'd3);
    begin
      int n = 0;
      while (q_bytes.size() < 2 && n < 1000) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("mid_reached", q_bytes.size(), 2);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_tx_data", tx_data, 0);
    chk("mid_owner", owner, 0);
    chk("mid_active", active, 0);
    chk("mid_tx_start", tx_start, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_start", q_bytes.size(), 0);
    chk("post_rst_ready", q_own.size(), 0);
    send(0, 32'h0000_00A5, 2'd0);
    wait_idle();
    chk("post_rst_n", q_bytes.size(), 1);
    chk("post_rst_b", q_bytes[0], 8'hA5);

`ifdef UART_TX_ARB_STATS_EN
    do_reset();
    busy_len = 0;
    for (int i = 0; i < 48; i++)
      send(0, 32'h0403_0201, 2'd3);
    wait_idle();
    chk("stats_b0", bytes0, 192);
    chk("stats_b1", bytes1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
